// File: rtl/frame_buffer_pkg.sv
// Shared constants and types for the frame buffer scheduler.
//   FB_PIXELS  : pixels per frame
//   FB_ADDR_W  : frame buffer address width
//   FB_DATA_W  : bits per pixel
//   fbs_state_t: top-level scheduler state
package frame_buffer_pkg;

    localparam int unsigned FB_PIXELS = 256000;
    localparam int unsigned FB_ADDR_W = 18;
    localparam int unsigned FB_DATA_W = 4;

    typedef enum logic [1:0] {
        WAIT_RDY,
        RUN,
        CLEAR
    } fbs_state_t;

endpackage

// File: rtl/frame_buffer_scheduler_fifo.sv
// Synchronous show-ahead FIFO used to prefetch scan-out pixels.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : drop all contents (wins over push/pop)
//   push       : write push_data (ignored when full)
//   pop        : consume head (ignored when empty)
//   head       : current head entry, zero while empty
//   level      : number of stored entries
//   empty      : no entries stored
module prefetch_fifo #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] level,
    output logic                   empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   level_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level_q == '0);
    assign full    = (level_q == (PTR_W + 1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign level   = level_q;
    assign head    = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                level_q <= level_q + 1'b1;
            end else if (do_pop && !do_push) begin
                level_q <= level_q - 1'b1;
            end
        end
    end

    // Storage carries no reset; head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Arbitrates all traffic into the frame buffer LRAM.
//   fb_ready / fb_rd_* / fb_wr_*        : frame buffer interface
//   px_valid/px_ready/px_addr/px_data   : pixel writer (graphics/SPI path)
//   clear_start/clear_color/clear_busy  : full-frame clear engine control
//   disp_frame_start/disp_pop/disp_data/disp_empty : display scan-out
//   underrun, px_dropped                : sticky error flags
module frame_buffer_scheduler
    import frame_buffer_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned FB_PIXELS  = frame_buffer_pkg::FB_PIXELS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fb_ready,
    output logic [FB_ADDR_W-1:0] fb_rd_addr,
    input  logic [FB_DATA_W-1:0] fb_rd_data,
    output logic [FB_ADDR_W-1:0] fb_wr_addr,
    output logic [FB_DATA_W-1:0] fb_wr_data,
    output logic                 fb_wr_en,
    input  logic                 px_valid,
    output logic                 px_ready,
    input  logic [FB_ADDR_W-1:0] px_addr,
    input  logic [FB_DATA_W-1:0] px_data,
    input  logic                 clear_start,
    input  logic [FB_DATA_W-1:0] clear_color,
    output logic                 clear_busy,
    input  logic                 disp_frame_start,
    input  logic                 disp_pop,
    output logic [FB_DATA_W-1:0] disp_data,
    output logic                 disp_empty,
    output logic                 underrun,
    output logic                 px_dropped
);

    localparam int unsigned LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FB_ADDR_W-1:0] PIXELS_A  = FB_ADDR_W'(FB_PIXELS);
    localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FB_PIXELS - 1);

    fbs_state_t state_q, state_d;

    // ---------------- FSM ----------------
    logic clr_write;
    logic clr_done;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            WAIT_RDY: if (fb_ready) state_d = RUN;
            RUN: begin
                if (!fb_ready) begin
                    state_d = WAIT_RDY;
                end else if (clear_start) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                if (!fb_ready) begin
                    state_d = WAIT_RDY;
                end else if (clr_done) begin
                    state_d = RUN;
                end
            end
            default: state_d = WAIT_RDY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= WAIT_RDY;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- write port ----------------
    logic                 px_accept;
    logic                 px_in_range;
    logic                 clear_accept;
    logic                 px_wr_en_q;
    logic [FB_ADDR_W-1:0] px_wr_addr_q;
    logic [FB_DATA_W-1:0] px_wr_data_q;
    logic [FB_ADDR_W-1:0] clr_addr_q;
    logic [FB_DATA_W-1:0] clr_color_q;

    assign px_ready     = (state_q == RUN);
    assign px_accept    = px_valid && px_ready;
    assign px_in_range  = (px_addr < PIXELS_A);
    assign clear_accept = (state_q == RUN) && fb_ready && clear_start;
    // A pixel accepted alongside clear_start still owns the port for one cycle,
    // so the clear engine holds off until that write has gone out.
    assign clr_write    = (state_q == CLEAR) && !px_wr_en_q;
    assign clr_done     = clr_write && (clr_addr_q == LAST_ADDR);
    assign clear_busy   = (state_q == CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px_wr_en_q   <= 1'b0;
            px_wr_addr_q <= '0;
            px_wr_data_q <= '0;
            px_dropped   <= 1'b0;
        end else begin
            px_wr_en_q <= px_accept && px_in_range;
            if (px_accept && px_in_range) begin
                px_wr_addr_q <= px_addr;
                px_wr_data_q <= px_data;
            end
            if (px_accept && !px_in_range) begin
                px_dropped <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_addr_q  <= '0;
            clr_color_q <= '0;
        end else if (clear_accept) begin
            clr_addr_q  <= '0;
            clr_color_q <= clear_color;
        end else if (clr_write) begin
            clr_addr_q <= clr_addr_q + 1'b1;
        end
    end

    assign fb_wr_en   = px_wr_en_q || clr_write;
    assign fb_wr_addr = clr_write ? clr_addr_q : px_wr_addr_q;
    assign fb_wr_data = clr_write ? clr_color_q : px_wr_data_q;

    // ---------------- read engine ----------------
    logic                 rd_active_q;
    logic                 rd_inflight_q;
    logic [FB_ADDR_W-1:0] rd_addr_q;
    logic                 rd_issue;
    logic                 fifo_push;
    logic [LVL_W-1:0]     fifo_level;
    logic [LVL_W:0]       occupancy;

    // Count the outstanding read so the FIFO can never be over-committed.
    assign occupancy = {1'b0, fifo_level} + {{LVL_W{1'b0}}, rd_inflight_q};
    assign rd_issue  = rd_active_q && (state_q != WAIT_RDY) && !disp_frame_start
                       && (occupancy < (LVL_W + 1)'(FIFO_DEPTH));
    // A frame restart discards whatever read was in flight.
    assign fifo_push = rd_inflight_q && !disp_frame_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_active_q   <= 1'b0;
            rd_inflight_q <= 1'b0;
            rd_addr_q     <= '0;
        end else if (disp_frame_start) begin
            rd_active_q   <= 1'b1;
            rd_inflight_q <= 1'b0;
            rd_addr_q     <= '0;
        end else begin
            rd_inflight_q <= rd_issue;
            if (rd_issue) begin
                // Last pixel of the frame: stop without wrapping; address holds.
                if (rd_addr_q == LAST_ADDR) begin
                    rd_active_q <= 1'b0;
                end else begin
                    rd_addr_q <= rd_addr_q + 1'b1;
                end
            end
        end
    end

    assign fb_rd_addr = rd_addr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            underrun <= 1'b0;
        end else if (disp_frame_start) begin
            underrun <= 1'b0;
        end else if (disp_pop && disp_empty) begin
            underrun <= 1'b1;
        end
    end

    prefetch_fifo #(
        .WIDTH (FB_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (disp_frame_start),
        .push      (fifo_push),
        .push_data (fb_rd_data),
        .pop       (disp_pop),
        .head      (disp_data),
        .level     (fifo_level),
        .empty     (disp_empty)
    );

endmodule
